coldata_i2c_v1_0: RTL and testbench

COLDATA_I2C_V1_0 -- requirements
Module: coldata_i2c_v1_0

---
 rtl/coldata_i2c_v1_0.sv | 237 +++++++++++++++++++++++
 tb/tb_coldata_i2c_v1_0.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coldata_i2c_v1_0.sv
// AXI-Lite controlled serial master for COLDATA: sends a 27-bit frame on scl/sda
// (differential data out), samples the returned bits and reports ack errors.
module coldata_i2c_v1_0 #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 5
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              scl,
  output logic                              sda_out_p,
  output logic                              sda_out_n,
  input  logic                              sda_in_p,
  input  logic                              sda_in_n
);
  localparam int DW = C_S00_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, START, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH, DONE
  } state_t;

  state_t          state;
  logic [DW-1:0]   ctrl_reg, tx_reg, div_reg, delay_reg;
  logic [DW-1:0]   rd_val;
  logic [2:0]      ar_idx;
  logic [7:0]      cnt, div_l, eff_delay;
  logic [3:0]      dly_l;
  logic [4:0]      idx, nxt_idx;
  logic [26:0]     frame, rx;
  logic [2:0]      ack_err;
  logic            busy, done, go_prev, stop_phase;
  logic            half_end;
  logic            unused;

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;
  assign sda_out_n     = ~sda_out_p;

  assign half_end  = (cnt == div_l);
  assign eff_delay = ({4'b0, dly_l} > div_l) ? div_l : {4'b0, dly_l};
  assign nxt_idx   = idx - 5'd1;

  assign unused = ^{s00_axi_awprot, s00_axi_arprot, sda_in_n,
                    s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] data,
                                          input logic [DW/8-1:0] strb);
    logic [DW-1:0] res;
    res = old;
    for (int unsigned i = 0; i < DW / 8; i++)
      if (strb[i]) res[i*8 +: 8] = data[i*8 +: 8];
    return res;
  endfunction

  always_comb begin
    rd_val = '0;
    case (ar_idx)
      3'd0: rd_val = ctrl_reg;
      3'd1: rd_val = tx_reg;
      3'd2: rd_val = div_reg;
      3'd3: rd_val = {{(DW-5){1'b0}}, ack_err, done, busy};
      3'd4: rd_val = {{(DW-27){1'b0}}, rx};
      3'd5: rd_val = delay_reg;
      default: rd_val = '0;
    endcase
  end

  // AXI-Lite slave: register file writes and read data path
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      ar_idx          <= '0;
      ctrl_reg        <= '0;
      tx_reg          <= '0;
      div_reg         <= DW'(24);
      delay_reg       <= '0;
    end else begin
      if (s00_axi_bvalid && s00_axi_bready) s00_axi_bvalid <= 1'b0;
      if (!s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid) begin
        s00_axi_awready <= 1'b1;
        s00_axi_wready  <= 1'b1;
        s00_axi_bvalid  <= 1'b1;
        case (s00_axi_awaddr[4:2])
          3'd0: ctrl_reg  <= merge(ctrl_reg,  s00_axi_wdata, s00_axi_wstrb);
          3'd1: tx_reg    <= merge(tx_reg,    s00_axi_wdata, s00_axi_wstrb);
          3'd2: div_reg   <= merge(div_reg,   s00_axi_wdata, s00_axi_wstrb);
          3'd5: delay_reg <= merge(delay_reg, s00_axi_wdata, s00_axi_wstrb);
          default: ;
        endcase
      end else begin
        s00_axi_awready <= 1'b0;
        s00_axi_wready  <= 1'b0;
      end

      if (s00_axi_rvalid && s00_axi_rready) s00_axi_rvalid <= 1'b0;
      if (s00_axi_arready) begin
        s00_axi_arready <= 1'b0;
        s00_axi_rvalid  <= 1'b1;
        s00_axi_rdata   <= rd_val;
      end else if (s00_axi_arvalid && !s00_axi_rvalid) begin
        s00_axi_arready <= 1'b1;
        ar_idx          <= s00_axi_araddr[4:2];
      end
    end
  end

  // Serial engine; every half-period lasts div_l+1 clocks
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      state      <= IDLE;
      scl        <= 1'b1;
      sda_out_p  <= 1'b1;
      cnt        <= '0;
      div_l      <= '0;
      dly_l      <= '0;
      idx        <= '0;
      frame      <= '0;
      rx         <= '0;
      ack_err    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      go_prev    <= 1'b0;
      stop_phase <= 1'b0;
    end else begin
      go_prev <= ctrl_reg[0];
      case (state)
        IDLE: begin
          scl       <= 1'b1;
          sda_out_p <= 1'b1;
          if (ctrl_reg[0] && !go_prev) begin
            state     <= START;
            div_l     <= div_reg[7:0];
            dly_l     <= delay_reg[3:0];
            frame     <= tx_reg[26:0];
            rx        <= '0;
            ack_err   <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
            idx       <= 5'd26;
            sda_out_p <= 1'b0;
          end
        end
        START: begin
          cnt <= cnt + 8'd1;
          if (half_end) begin
            cnt       <= '0;
            state     <= BIT_LOW;
            scl       <= 1'b0;
            sda_out_p <= frame[idx];
          end
        end
        BIT_LOW: begin
          cnt <= cnt + 8'd1;
          if (half_end) begin
            cnt   <= '0;
            state <= BIT_HIGH;
            scl   <= 1'b1;
          end
        end
        BIT_HIGH: begin
          cnt <= cnt + 8'd1;
          if (cnt == eff_delay) begin
            rx[idx] <= sda_in_p;
            if (sda_in_p) begin
              if (idx == 5'd0)  ack_err[2] <= 1'b1;
              if (idx == 5'd9)  ack_err[1] <= 1'b1;
              if (idx == 5'd18) ack_err[0] <= 1'b1;
            end
          end
          if (half_end) begin
            cnt <= '0;
            scl <= 1'b0;
            if (idx == 5'd0) begin
              state     <= STOP_LOW;
              sda_out_p <= 1'b0;
            end else begin
              state     <= BIT_LOW;
              idx       <= nxt_idx;
              sda_out_p <= frame[nxt_idx];
            end
          end
        end
        STOP_LOW: begin
          cnt <= cnt + 8'd1;
          if (half_end) begin
            cnt        <= '0;
            state      <= STOP_HIGH;
            scl        <= 1'b1;
            stop_phase <= 1'b0;
          end
        end
        STOP_HIGH: begin
          // first half holds sda low, second half releases it (the stop condition)
          cnt <= cnt + 8'd1;
          if (half_end) begin
            cnt <= '0;
            if (!stop_phase) begin
              stop_phase <= 1'b1;
              sda_out_p  <= 1'b1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coldata_i2c_v1_0.sv
// Self-checking bench for coldata_i2c_v1_0: AXI register access, serial frame
// timing and bit order, ack errors, sample delay, ignored writes, mid-frame reset.
module tb_coldata_i2c_v1_0;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        scl, sda_out_p, sda_out_n, sda_in_p, sda_in_n;

  logic        lb_on, lb_const;
  int unsigned lb_lat;
  logic [15:0] pipe;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  localparam logic [26:0] FRAME = {8'hAA, 1'b0, 8'hF0, 1'b0, 8'hAA, 1'b0};
  localparam logic [4:0] A_CTRL = 5'h00, A_TX = 5'h04, A_DIV = 5'h08, A_STAT = 5'h0C,
                         A_RX = 5'h10, A_DLY = 5'h14, A_R6 = 5'h18, A_R7 = 5'h1C;

  always #5 clk = ~clk;

  // Return path model: either a constant level or sda_out_p delayed by lb_lat clocks
  always @(posedge clk) pipe <= {pipe[14:0], sda_out_p};
  assign sda_in_p = !lb_on ? lb_const : (lb_lat == 0) ? sda_out_p : pipe[lb_lat-1];
  assign sda_in_n = ~sda_in_p;

  coldata_i2c_v1_0 #(.C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(5)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .scl(scl), .sda_out_p(sda_out_p), .sda_out_n(sda_out_n),
    .sda_in_p(sda_in_p), .sda_in_n(sda_in_n)
  );

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int unsigned t;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    while (awready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    awvalid = 1'b0; wvalid = 1'b0;
    if (t >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL write_accept addr=%h: awready never seen, required within 20 clocks", addr);
      return;
    end
    t = 0;
    while (bvalid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_tests++;
    if (t >= 20) begin
      n_fail++;
      $display("FAIL write_resp addr=%h: bvalid never seen", addr);
      return;
    end
    if (bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL write_bresp addr=%h: got %b required 00", addr, bresp);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read_check(input logic [4:0] addr, input logic [31:0] expv,
                                input string nm);
    int unsigned t;
    logic [31:0] e;
    string       n;
    exp_q.push_back(expv);
    name_q.push_back(nm);
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    t = 0;
    while (arready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    arvalid = 1'b0;
    t = 0;
    while (rvalid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    e = exp_q.pop_front();
    n = name_q.pop_front();
    n_tests++;
    if (t >= 20) begin
      n_fail++;
      $display("FAIL %s: no read response, required %h", n, e);
      return;
    end
    if (rdata !== e || rresp !== 2'b00) begin
      n_fail++;
      $display("FAIL %s: rdata=%h rresp=%b, required %h / 00", n, rdata, rresp, e);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // Follows one transaction: bit order on scl rise, half-period lengths, total length
  task automatic monitor_frame(input logic [26:0] frame, input int unsigned div);
    logic        bq[$];
    logic        b, prev_scl;
    int unsigned t, busy_cnt, low_cnt, rises, n_diff;
    for (int i = 26; i >= 0; i--) bq.push_back(frame[i]);
    busy_cnt = 0; low_cnt = 0; rises = 0; n_diff = 0;
    t = 0;
    @(negedge clk);
    while (dut.busy !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin
      n_tests++; n_fail++;
      $display("FAIL frame_start: busy never rose after go");
      return;
    end
    prev_scl = 1'b1;
    while (dut.busy === 1'b1 && busy_cnt < 60000) begin
      busy_cnt++;
      if (scl === 1'b0) low_cnt++;
      if (sda_out_n !== ~sda_out_p) n_diff++;
      if (scl === 1'b1 && prev_scl === 1'b0) begin
        rises++;
        if (bq.size() > 0) begin
          b = bq.pop_front();
          n_tests++;
          if (sda_out_p !== b) begin
            n_fail++;
            $display("FAIL frame_bit%0d: sda_out_p=%b required %b", bq.size(), sda_out_p, b);
          end
        end
      end
      prev_scl = scl;
      @(negedge clk);
    end
    n_tests++;
    if (dut.done !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_done: done=%b required 1 when busy falls", dut.done);
    end
    n_tests++;
    if (busy_cnt + 1 != 58 * (div + 1) + 1) begin
      n_fail++;
      $display("FAIL frame_length: %0d clocks, required %0d", busy_cnt + 1, 58 * (div + 1) + 1);
    end
    n_tests++;
    if (rises != 28 || low_cnt != 28 * (div + 1)) begin
      n_fail++;
      $display("FAIL frame_scl: rises=%0d low=%0d, required 28 / %0d", rises, low_cnt, 28 * (div + 1));
    end
    n_tests++;
    if (n_diff != 0 || bq.size() != 0) begin
      n_fail++;
      $display("FAIL frame_diff: n_mismatch=%0d bits_left=%0d, required 0 / 0", n_diff, bq.size());
    end
  endtask

  task automatic run_frame(input int unsigned div, input logic [3:0] dly,
                           input logic [26:0] frame);
    axi_write(A_DIV, 32'(div), 4'hF);
    axi_write(A_DLY, {28'b0, dly}, 4'hF);
    axi_write(A_TX, {5'b0, frame}, 4'hF);
    axi_write(A_CTRL, 32'h0, 4'hF);
    fork
      axi_write(A_CTRL, 32'h1, 4'hF);
      monitor_frame(frame, div);
    join
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({scl, sda_out_p, sda_out_n, awready, wready, bvalid, arready, rvalid} !== 8'b1100_0000) begin
      n_fail++;
      $display("FAIL reset_pins: %b required 11000000",
               {scl, sda_out_p, sda_out_n, awready, wready, bvalid, arready, rvalid});
    end
    rst = 1'b0;
    axi_read_check(A_CTRL, 32'h0,  "reset_ctrl");
    axi_read_check(A_TX,   32'h0,  "reset_tx");
    axi_read_check(A_DIV,  32'd24, "reset_div");
    axi_read_check(A_STAT, 32'h0,  "reset_status");
    axi_read_check(A_RX,   32'h0,  "reset_rx");
    axi_read_check(A_DLY,  32'h0,  "reset_delay");
    axi_read_check(A_R6,   32'h0,  "reset_addr6");
    axi_read_check(A_R7,   32'h0,  "reset_addr7");
  endtask

  task automatic test_loopback_div0;
    lb_on = 1'b1; lb_lat = 0;
    run_frame(0, 4'd0, FRAME);
    axi_read_check(A_RX,   {5'b0, FRAME}, "loop0_rx");
    axi_read_check(A_STAT, 32'h2,         "loop0_status");
  endtask

  task automatic test_ack_error;
    lb_on = 1'b0; lb_const = 1'b1;
    run_frame(0, 4'd0, FRAME);
    axi_read_check(A_STAT, 32'h1E,       "ackerr_status");
    axi_read_check(A_RX,   32'h07FF_FFFF, "ackerr_rx");
  endtask

  task automatic test_sample_delay;
    logic [26:0] shifted;
    // a 10-clock return lands an unskewed sample inside the previous bit
    shifted = FRAME >> 1;
    lb_on = 1'b1; lb_lat = 10;
    run_frame(7, 4'd0, FRAME);
    axi_read_check(A_RX,   {5'b0, shifted}, "delay0_rx");
    axi_read_check(A_STAT, 32'h2,           "delay0_status");
    run_frame(7, 4'd4, FRAME);
    axi_read_check(A_RX,   {5'b0, FRAME}, "delay4_rx");
    axi_read_check(A_STAT, 32'h2,         "delay4_status");
    run_frame(7, 4'd15, FRAME);
    axi_read_check(A_RX,   {5'b0, FRAME}, "delay15_clamped_rx");
    axi_read_check(A_DLY,  32'hF,         "delay15_readback");
  endtask

  task automatic test_ignored_writes;
    logic [26:0] tx_mod;
    lb_on = 1'b0; lb_const = 1'b0;
    axi_write(A_DIV, 32'd7, 4'hF);
    axi_write(A_DLY, 32'd3, 4'hF);
    axi_write(A_TX, {5'b0, FRAME}, 4'hF);
    axi_write(A_CTRL, 32'h0, 4'hF);
    fork
      begin
        axi_write(A_CTRL, 32'h1, 4'hF);
        repeat (100) @(negedge clk);
        axi_write(A_CTRL, 32'h0, 4'hF);
        axi_write(A_CTRL, 32'h1, 4'hF);
        axi_write(A_TX, 32'h0001_2345, 4'h0);
        axi_write(A_DIV, 32'h0000_00FF, 4'h0);
        axi_write(A_DLY, 32'h0000_000F, 4'h0);
        axi_write(A_STAT, 32'hFFFF_FFFF, 4'hF);
      end
      monitor_frame(FRAME, 7);
    join
    repeat (20) @(negedge clk);
    axi_read_check(A_STAT, 32'h2,         "norestart_status");
    axi_read_check(A_CTRL, 32'h1,         "norestart_ctrl");
    axi_read_check(A_TX,   {5'b0, FRAME}, "strb0_tx");
    axi_read_check(A_DIV,  32'd7,         "strb0_div");
    axi_read_check(A_DLY,  32'd3,         "strb0_delay");
    tx_mod = {FRAME[26:8], 8'hFF};
    axi_write(A_TX, 32'hFFFF_FFFF, 4'b0001);
    axi_read_check(A_TX,   {5'b0, tx_mod}, "strb_byte0_tx");
  endtask

  task automatic test_reset_mid;
    int unsigned rises, t;
    logic        prev_scl;
    lb_on = 1'b0; lb_const = 1'b0;
    axi_write(A_CTRL, 32'h0, 4'hF);
    axi_write(A_TX, {5'b0, FRAME}, 4'hF);
    axi_write(A_DIV, 32'd7, 4'hF);
    axi_write(A_CTRL, 32'h1, 4'hF);
    rises = 0; t = 0; prev_scl = scl;
    // the 17th scl rise is the high half of bit 10
    while (rises < 17 && t < 2000) begin
      @(negedge clk);
      t++;
      if (scl === 1'b1 && prev_scl === 1'b0) rises++;
      prev_scl = scl;
    end
    n_tests++;
    if (rises < 17) begin
      n_fail++;
      $display("FAIL midreset_reach: %0d scl rises, required 17", rises);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({scl, sda_out_p, sda_out_n, awready, wready, bvalid, arready, rvalid} !== 8'b1100_0000) begin
      n_fail++;
      $display("FAIL midreset_pins: %b required 11000000",
               {scl, sda_out_p, sda_out_n, awready, wready, bvalid, arready, rvalid});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    axi_read_check(A_STAT, 32'h0,  "midreset_status");
    axi_read_check(A_DIV,  32'd24, "midreset_div");
    axi_read_check(A_TX,   32'h0,  "midreset_tx");
    axi_read_check(A_RX,   32'h0,  "midreset_rx");
    axi_read_check(A_CTRL, 32'h0,  "midreset_ctrl");
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    lb_on = 1'b0; lb_const = 1'b0; lb_lat = 0;
    test_reset;
    test_loopback_div0;
    test_ack_error;
    test_sample_delay;
    test_ignored_writes;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
